// File: rtl/ext_irq_ctrl_if.sv
// Bus between the external interrupt controller and its surroundings.
// The master side drives the peripheral lines, the mask and the ack. The slave side is the controller.
interface ext_irq_ctrl_if #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   irq_in;
  logic           mask_we;
  logic [N-1:0]   mask_wdata;
  logic           ExtIAck;
  logic           ExtIRQ;
  logic [IDW-1:0] irq_id;
  logic [N-1:0]   pending;
  logic [N-1:0]   mask;

  modport master (
    output irq_in, mask_we, mask_wdata, ExtIAck,
    input  ExtIRQ, irq_id, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, ExtIAck,
    output ExtIRQ, irq_id, pending, mask
  );
endinterface

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller.
// It captures rising edges into a pending register and applies a mask. It holds one level request, for the lowest enabled source, until that request is acknowledged.
module ext_irq_ctrl #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  ext_irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   prev_q, prev_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   mask_q, mask_d;
  logic [IDW-1:0] irq_id_q, irq_id_d;
  logic           ext_irq_q, ext_irq_d;

  logic [N-1:0]   rise;
  logic [N-1:0]   eligible;
  logic [N-1:0]   clr;
  logic [IDW-1:0] sel_id;

  // Lowest-index enabled pending source (descending scan, last hit wins)
  always_comb begin
    eligible = pending_q & mask_q;
    sel_id   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (eligible[i]) sel_id = IDW'(i);
    end
  end

  // Next-state, request and register update logic
  always_comb begin
    state_d   = state_q;
    irq_id_d  = irq_id_q;
    ext_irq_d = ext_irq_q;
    prev_d    = bus.irq_in;
    mask_d    = bus.mask_we ? bus.mask_wdata : mask_q;
    rise      = bus.irq_in & ~prev_q;
    clr       = '0;

    case (state_q)
      ST_IDLE: begin
        ext_irq_d = 1'b0;
        if (eligible != '0) begin
          state_d   = ST_REQ;
          irq_id_d  = sel_id;
          ext_irq_d = 1'b1;
        end
      end
      ST_REQ: begin
        ext_irq_d = 1'b1;
        if (bus.ExtIAck) begin
          for (int i = 0; i < int'(N); i++) begin
            clr[i] = (irq_id_q == IDW'(i));
          end
          state_d   = ST_GAP;
          ext_irq_d = 1'b0;
        end
      end
      ST_GAP: begin
        ext_irq_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        ext_irq_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // A new edge on the bit being acknowledged keeps it pending
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      prev_q    <= '1;
      pending_q <= '0;
      mask_q    <= '0;
      irq_id_q  <= '0;
      ext_irq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_id_q  <= irq_id_d;
      ext_irq_q <= ext_irq_d;
    end
  end

  assign bus.ExtIRQ  = ext_irq_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed bench for ext_irq_ctrl.
// A behavioural model is checked against the DUT on every falling edge, and literal expectations pin key cycles.
module tb_ext_irq_ctrl;
  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ext_irq_ctrl_if #(.N(N), .IDW(IDW)) bif ();

  ext_irq_ctrl #(.N(N), .IDW(IDW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a request flag, the requested id and a cool-down counter after each ack
  logic [N-1:0]   m_pend, m_mask, m_prev, m_rise, m_elig;
  logic           m_req;
  logic [IDW-1:0] m_id;
  int             m_cool;
  bit             m_valid = 1'b0;

  function automatic logic [IDW-1:0] lowest(input logic [N-1:0] v);
    for (int i = 0; i < int'(N); i++) if (v[i]) return IDW'(i);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_mask = '0; m_prev = '1;
      m_req = 1'b0; m_id = '0; m_cool = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_rise = bif.irq_in & ~m_prev;
      m_elig = m_pend & m_mask;
      if (m_req) begin
        if (bif.ExtIAck) begin
          m_pend[m_id] = 1'b0;
          m_req  = 1'b0;
          m_cool = 1;
        end
      end else if (m_cool > 0) begin
        m_cool = m_cool - 1;
      end else if (m_elig != '0) begin
        m_req = 1'b1;
        m_id  = lowest(m_elig);
      end
      m_pend = m_pend | m_rise;
      if (bif.mask_we) m_mask = bif.mask_wdata;
      m_prev = bif.irq_in;
    end
  end

  // Model comparison on every falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("ExtIRQ", 32'(bif.ExtIRQ), 32'(m_req));
      chk("pending", 32'(bif.pending), 32'(m_pend));
      chk("mask", 32'(bif.mask), 32'(m_mask));
      if (m_req) chk("irq_id", 32'(bif.irq_id), 32'(m_id));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_mask(input logic [N-1:0] v);
    bif.mask_we = 1'b1; bif.mask_wdata = v;
    tick(1);
    bif.mask_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bif.irq_in = 4'b0001; bif.mask_we = 1'b0; bif.mask_wdata = '0; bif.ExtIAck = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_pending", 32'(bif.pending), 32'h0);
    chk("rst_irq", 32'(bif.ExtIRQ), 32'h0);
    chk("rst_id", 32'(bif.irq_id), 32'h0);
    tick(5);
    chk("held_line_pending", 32'(bif.pending), 32'h0);
    chk("held_line_irq", 32'(bif.ExtIRQ), 32'h0);

    // Drop and re-raise bit 0 with the mask enabling it
    wr_mask(4'b0001);
    bif.irq_in = 4'b0000; tick(1);
    bif.irq_in = 4'b0001; tick(1);
    chk("b0_pending", 32'(bif.pending), 32'h1);
    chk("b0_irq_early", 32'(bif.ExtIRQ), 32'h0);
    tick(1);
    chk("b0_irq", 32'(bif.ExtIRQ), 32'h1);
    chk("b0_id", 32'(bif.irq_id), 32'h0);
    bif.ExtIAck = 1'b1; tick(1); bif.ExtIAck = 1'b0;
    chk("b0_ack_irq", 32'(bif.ExtIRQ), 32'h0);
    chk("b0_ack_pend", 32'(bif.pending), 32'h0);
    tick(1);
    bif.irq_in = 4'b0000;

    // Bits 2 and 1 rise together
    wr_mask(4'b1111);
    bif.irq_in = 4'b0110; tick(1);
    chk("p21_pending", 32'(bif.pending), 32'h6);
    tick(1);
    chk("p21_first_id", 32'(bif.irq_id), 32'h1);
    chk("p21_first_irq", 32'(bif.ExtIRQ), 32'h1);
    bif.ExtIAck = 1'b1; tick(1); bif.ExtIAck = 1'b0;
    chk("p21_gap_irq", 32'(bif.ExtIRQ), 32'h0);
    chk("p21_gap_pend", 32'(bif.pending), 32'h4);
    tick(1);
    chk("p21_idle_irq", 32'(bif.ExtIRQ), 32'h0);
    tick(1);
    chk("p21_second_irq", 32'(bif.ExtIRQ), 32'h1);
    chk("p21_second_id", 32'(bif.irq_id), 32'h2);
    bif.ExtIAck = 1'b1; tick(1); bif.ExtIAck = 1'b0;
    chk("p21_all_clear", 32'(bif.pending), 32'h0);
    tick(2);
    bif.irq_in = 4'b0000;

    // Masked source accumulates, then the mask is opened
    wr_mask(4'b0000);
    bif.irq_in = 4'b1000; tick(1);
    chk("m3_pending", 32'(bif.pending), 32'h8);
    tick(3);
    chk("m3_masked_irq", 32'(bif.ExtIRQ), 32'h0);
    wr_mask(4'b1000);
    chk("m3_write_irq", 32'(bif.ExtIRQ), 32'h0);
    tick(1);
    chk("m3_irq", 32'(bif.ExtIRQ), 32'h1);
    chk("m3_id", 32'(bif.irq_id), 32'h3);
    bif.ExtIAck = 1'b1; tick(1); bif.ExtIAck = 1'b0;
    tick(1);
    bif.irq_in = 4'b0000;

    // A mask write while requesting must not withdraw the request
    wr_mask(4'b1111);
    bif.irq_in = 4'b0001; tick(2);
    chk("rq_irq", 32'(bif.ExtIRQ), 32'h1);
    wr_mask(4'b0000);
    tick(3);
    chk("rq_hold_irq", 32'(bif.ExtIRQ), 32'h1);
    chk("rq_hold_id", 32'(bif.irq_id), 32'h0);
    chk("rq_mask", 32'(bif.mask), 32'h0);
    bif.ExtIAck = 1'b1; tick(1);
    tick(1); bif.ExtIAck = 1'b0;
    chk("gap_ack_pend", 32'(bif.pending), 32'h0);
    chk("gap_ack_irq", 32'(bif.ExtIRQ), 32'h0);
    bif.irq_in = 4'b0100; tick(1);
    bif.ExtIAck = 1'b1; tick(2); bif.ExtIAck = 1'b0;
    chk("idle_ack_pend", 32'(bif.pending), 32'h4);
    chk("idle_ack_irq", 32'(bif.ExtIRQ), 32'h0);
    bif.irq_in = 4'b0000;

    // An ack and a new rise on the same bit in the same cycle
    wr_mask(4'b0001);
    bif.irq_in = 4'b0001; tick(1);
    chk("sw_pending", 32'(bif.pending), 32'h5);
    tick(1);
    chk("sw_irq", 32'(bif.ExtIRQ), 32'h1);
    bif.irq_in = 4'b0000; tick(1);
    bif.irq_in = 4'b0001; bif.ExtIAck = 1'b1; tick(1); bif.ExtIAck = 1'b0;
    chk("sw_gap_irq", 32'(bif.ExtIRQ), 32'h0);
    chk("sw_set_wins", 32'(bif.pending), 32'h5);
    tick(1);
    chk("sw_idle_irq", 32'(bif.ExtIRQ), 32'h0);
    tick(1);
    chk("sw_again_irq", 32'(bif.ExtIRQ), 32'h1);
    chk("sw_again_id", 32'(bif.irq_id), 32'h0);

    // Reset during a request, with an ack and a mask write in the same cycle
    reset = 1'b1; bif.ExtIAck = 1'b1; bif.mask_we = 1'b1; bif.mask_wdata = 4'b1111;
    tick(1);
    reset = 1'b0; bif.ExtIAck = 1'b0; bif.mask_we = 1'b0;
    chk("rr_irq", 32'(bif.ExtIRQ), 32'h0);
    chk("rr_id", 32'(bif.irq_id), 32'h0);
    chk("rr_pending", 32'(bif.pending), 32'h0);
    chk("rr_mask", 32'(bif.mask), 32'h0);
    tick(4);
    chk("rr_quiet_irq", 32'(bif.ExtIRQ), 32'h0);
    chk("rr_quiet_pend", 32'(bif.pending), 32'h0);
    bif.irq_in = 4'b0000; tick(1);
    bif.irq_in = 4'b0001; tick(3);
    chk("rr_edge_pend", 32'(bif.pending), 32'h1);
    chk("rr_edge_noirq", 32'(bif.ExtIRQ), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
